// File: rtl/uart_tx_sequencer_if.sv
// Request/transmit signal bundle for uart_tx_sequencer.
// The echo signals exist only when TX_ECHO_EN is defined.
interface uart_tx_sequencer_if;
    logic        result_req;
    logic [15:0] result_data;
`ifdef TX_ECHO_EN
    logic        echo_req;
    logic [7:0]  echo_data;
`endif
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        overrun;

    // Master is the host side that raises requests and models the UART TX core.
    modport master (
`ifdef TX_ECHO_EN
        output echo_req, echo_data,
`endif
        output result_req, result_data, tx_busy,
        input  tx_start, tx_data, busy, done, overrun
    );

    modport slave (
`ifdef TX_ECHO_EN
        input  echo_req, echo_data,
`endif
        input  result_req, result_data, tx_busy,
        output tx_start, tx_data, busy, done, overrun
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Latches ALU results (and echo bytes when TX_ECHO_EN is defined), splits them into bytes
// and sequences each byte through the UART TX core with a settle delay and start/busy handshake.
module uart_tx_sequencer #(
    parameter int WAIT_FOR_REGISTER_DELAY = 100
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_sequencer_if.slave bus
);
    localparam int CNT_W = (WAIT_FOR_REGISTER_DELAY > 1) ? $clog2(WAIT_FOR_REGISTER_DELAY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_REG, START, WAIT_HI, WAIT_LO, NEXT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       msg_hi;
    logic             last_byte;

    logic             res_flag;
    logic [15:0]      res_data;
    logic             grant_res;
    logic             req_overrun;

`ifdef TX_ECHO_EN
    logic             ech_flag;
    logic [7:0]       ech_data;
    logic             grant_ech;

    // Echo wins when both slots are pending; grants only happen between messages.
    assign grant_ech   = (state == IDLE) && ech_flag;
    assign grant_res   = (state == IDLE) && res_flag && !ech_flag;
    assign req_overrun = (bus.result_req && res_flag && !grant_res) ||
                         (bus.echo_req   && ech_flag && !grant_ech);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ech_flag <= 1'b0;
            ech_data <= '0;
        end else if (bus.echo_req) begin
            ech_flag <= 1'b1;
            ech_data <= bus.echo_data;
        end else if (grant_ech) begin
            ech_flag <= 1'b0;
        end
    end
`else
    assign grant_res   = (state == IDLE) && res_flag;
    assign req_overrun = bus.result_req && res_flag && !grant_res;
`endif

    // A request in the grant cycle refills the slot, so it is not counted as an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_flag <= 1'b0;
            res_data <= '0;
        end else if (bus.result_req) begin
            res_flag <= 1'b1;
            res_data <= bus.result_data;
        end else if (grant_res) begin
            res_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            msg_hi       <= '0;
            last_byte    <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; a later non-blocking write in the case wins.
            bus.tx_start <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= req_overrun;
            case (state)
                IDLE: begin
`ifdef TX_ECHO_EN
                    if (grant_ech) begin
                        state       <= LOAD;
                        bus.busy    <= 1'b1;
                        bus.tx_data <= ech_data;
                        last_byte   <= 1'b1;
                    end else
`endif
                    if (grant_res) begin
                        state       <= LOAD;
                        bus.busy    <= 1'b1;
                        bus.tx_data <= res_data[7:0];
                        msg_hi      <= res_data[15:8];
                        last_byte   <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt <= CNT_W'(WAIT_FOR_REGISTER_DELAY);
                    if (WAIT_FOR_REGISTER_DELAY == 0) begin
                        state        <= START;
                        bus.tx_start <= 1'b1;
                    end else begin
                        state <= WAIT_REG;
                    end
                end
                WAIT_REG: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= START;
                        bus.tx_start <= 1'b1;
                    end
                end
                START: state <= WAIT_HI;
                WAIT_HI: begin
                    if (bus.tx_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        state    <= NEXT;
                        bus.done <= last_byte;
                    end
                end
                NEXT: begin
                    if (!last_byte) begin
                        state       <= LOAD;
                        bus.tx_data <= msg_hi;
                        last_byte   <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: one instance with a 3-cycle settle delay, one with 0.
// Echo scenarios run only when TX_ECHO_EN is defined.
module tb_uart_tx_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_sequencer_if bus3();
    uart_tx_sequencer_if bus0();

    uart_tx_sequencer #(.WAIT_FOR_REGISTER_DELAY(3)) dut3 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus3.slave)
    );

    uart_tx_sequencer #(.WAIT_FOR_REGISTER_DELAY(0)) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q3[$];
    logic [7:0] q0[$];
    int start3_q[$];
    int fall3_q[$];
    int start0_q[$];
    int fall0_q[$];
    int start_cnt3 = 0, done_cnt3 = 0, ov_cnt3 = 0;
    int start_cnt0 = 0, done_cnt0 = 0;
    int delay3 = 0, hold3 = 10;
    logic [7:0] exp3, exp0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART TX core models: raise tx_busy after a delay, hold it, then drop it.
    initial begin
        bus3.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus3.tx_start === 1'b1) begin
                repeat (delay3) @(negedge clk);
                bus3.tx_busy = 1'b1;
                repeat (hold3) @(negedge clk);
                bus3.tx_busy = 1'b0;
                fall3_q.push_back(cyc);
            end
        end
    end

    initial begin
        bus0.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus0.tx_start === 1'b1) begin
                bus0.tx_busy = 1'b1;
                repeat (4) @(negedge clk);
                bus0.tx_busy = 1'b0;
                fall0_q.push_back(cyc);
            end
        end
    end

    // Scoreboard monitors: every tx_start pops the next expected byte.
    initial forever begin
        @(negedge clk);
        if (bus3.tx_start === 1'b1) begin
            start3_q.push_back(cyc);
            start_cnt3++;
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL d3_tx_byte: got %h, expected no transmission", bus3.tx_data);
            end else begin
                exp3 = q3.pop_front();
                if (bus3.tx_data !== exp3) begin
                    n_fail++;
                    $display("FAIL d3_tx_byte: got %h, expected %h", bus3.tx_data, exp3);
                end
            end
        end
        if (bus3.done === 1'b1) done_cnt3++;
        if (bus3.overrun === 1'b1) ov_cnt3++;
    end

    initial forever begin
        @(negedge clk);
        if (bus0.tx_start === 1'b1) begin
            start0_q.push_back(cyc);
            start_cnt0++;
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL d0_tx_byte: got %h, expected no transmission", bus0.tx_data);
            end else begin
                exp0 = q0.pop_front();
                if (bus0.tx_data !== exp0) begin
                    n_fail++;
                    $display("FAIL d0_tx_byte: got %h, expected %h", bus0.tx_data, exp0);
                end
            end
        end
        if (bus0.done === 1'b1) done_cnt0++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic req_res3(input logic [15:0] d);
        bus3.result_req  = 1'b1;
        bus3.result_data = d;
        @(negedge clk);
        bus3.result_req  = 1'b0;
    endtask

    task automatic wait_done3(input int n, input int bound, input string name);
        int seen = 0;
        for (int i = 0; i < bound && seen < n; i++) begin
            @(negedge clk);
            if (bus3.done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != n) begin
            n_fail++;
            $display("FAIL %s: saw %0d done pulses, expected %0d within %0d cycles", name, seen, n, bound);
        end
    endtask

    task automatic wait_start3(input int bound, input string name);
        int ok = 0;
        for (int i = 0; i < bound && ok == 0; i++) begin
            @(negedge clk);
            if (bus3.tx_start === 1'b1) ok = 1;
        end
        n_checks++;
        if (ok == 0) begin
            n_fail++;
            $display("FAIL %s: no tx_start within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus3.tx_start, bus3.tx_data, bus3.busy, bus3.done, bus3.overrun};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_d3: outputs %h, expected 000", obs);
        end
        obs = {bus0.tx_start, bus0.tx_data, bus0.busy, bus0.done, bus0.overrun};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_d0: outputs %h, expected 000", obs);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        obs = {bus3.tx_start, bus3.tx_data, bus3.busy, bus3.done, bus3.overrun};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL idle_after_reset_d3: outputs %h, expected 000", obs);
        end
    endtask

    task automatic test_result_split();
        int c, st0, dn0;
        delay3 = 0;
        hold3  = 10;
        start3_q.delete();
        fall3_q.delete();
        st0 = start_cnt3;
        dn0 = done_cnt3;
        c   = cyc;
        q3.push_back(8'hEF);
        q3.push_back(8'hBE);
        req_res3(16'hBEEF);
        wait_done3(1, 200, "beef_done");
        repeat (10) @(negedge clk);
        n_checks++;
        if (start_cnt3 - st0 != 2) begin
            n_fail++;
            $display("FAIL beef_start_count: got %0d, expected 2", start_cnt3 - st0);
        end
        n_checks++;
        if (done_cnt3 - dn0 != 1) begin
            n_fail++;
            $display("FAIL beef_done_count: got %0d, expected 1", done_cnt3 - dn0);
        end
        n_checks++;
        if (start3_q.size() < 2 || fall3_q.size() < 1) begin
            n_fail++;
            $display("FAIL beef_timing: %0d starts / %0d falls recorded", start3_q.size(), fall3_q.size());
        end else begin
            if (start3_q[0] != c + 6) begin
                n_fail++;
                $display("FAIL beef_first_start: cycle %0d, expected %0d", start3_q[0], c + 6);
            end
            n_checks++;
            if (start3_q[1] != fall3_q[0] + 6) begin
                n_fail++;
                $display("FAIL beef_second_start: cycle %0d, expected %0d", start3_q[1], fall3_q[0] + 6);
            end
        end
        n_checks++;
        if (q3.size() != 0 || bus3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL beef_drain: %0d bytes left, busy %b, expected 0 and 0", q3.size(), bus3.busy);
        end
    endtask

    task automatic test_pending_overrun();
        int ov0, dn0;
        ov0 = ov_cnt3;
        dn0 = done_cnt3;
        q3.push_back(8'h11);
        q3.push_back(8'h11);
        req_res3(16'h1111);
        wait_start3(50, "pend_first_start");
        req_res3(16'h2222);
        q3.push_back(8'h44);
        q3.push_back(8'h44);
        req_res3(16'h4444);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ov_cnt3 - ov0 != 1) begin
            n_fail++;
            $display("FAIL pend_overrun: %0d pulses, expected 1", ov_cnt3 - ov0);
        end
        wait_done3(1, 200, "pend_done_a");
        @(negedge clk);
        q3.push_back(8'h33);
        q3.push_back(8'h33);
        req_res3(16'h3333);
        wait_done3(2, 400, "pend_done_dc");
        repeat (3) @(negedge clk);
        n_checks++;
        if (ov_cnt3 - ov0 != 1) begin
            n_fail++;
            $display("FAIL grant_cycle_request: %0d overrun pulses, expected 1", ov_cnt3 - ov0);
        end
        n_checks++;
        if (q3.size() != 0 || done_cnt3 - dn0 != 3) begin
            n_fail++;
            $display("FAIL pend_drain: %0d bytes left, %0d done, expected 0 and 3", q3.size(), done_cnt3 - dn0);
        end
    endtask

    task automatic test_reset_mid_message();
        logic [11:0] obs;
        int st0;
        q3.push_back(8'hAA);
        req_res3(16'hAAAA);
        wait_start3(50, "rst_first_start");
        req_res3(16'h5555);
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus3.busy !== 1'b1 || bus3.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_state: busy %b tx_busy %b, expected 1 1", bus3.busy, bus3.tx_busy);
        end
        #2;
        reset = 1'b0;
        #1;
        obs = {bus3.tx_start, bus3.tx_data, bus3.busy, bus3.done, bus3.overrun};
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_async: outputs %h, expected 000", obs);
        end
        @(negedge clk);
        reset = 1'b1;
        st0 = start_cnt3;
        repeat (40) @(negedge clk);
        n_checks++;
        if (start_cnt3 != st0 || bus3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_resume: %0d starts busy %b, expected 0 starts busy 0", start_cnt3 - st0, bus3.busy);
        end
        q3.push_back(8'hA5);
        q3.push_back(8'hC3);
        req_res3(16'hC3A5);
        wait_done3(1, 200, "rst_new_request");
        n_checks++;
        if (q3.size() != 0) begin
            n_fail++;
            $display("FAIL rst_new_drain: %0d bytes left, expected 0", q3.size());
        end
    endtask

    task automatic test_busy_delay();
        int st0;
        delay3 = 5;
        hold3  = 4;
        start3_q.delete();
        fall3_q.delete();
        st0 = start_cnt3;
        q3.push_back(8'h3C);
        q3.push_back(8'h9A);
        req_res3(16'h9A3C);
        wait_start3(50, "delay_first_start");
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus3.busy !== 1'b1 || start_cnt3 - st0 != 1) begin
            n_fail++;
            $display("FAIL delay_hold: busy %b starts %0d, expected 1 and 1", bus3.busy, start_cnt3 - st0);
        end
        wait_done3(1, 200, "delay_done");
        repeat (5) @(negedge clk);
        n_checks++;
        if (start_cnt3 - st0 != 2 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL delay_starts: %0d starts %0d left, expected 2 and 0", start_cnt3 - st0, q3.size());
        end
        n_checks++;
        if (start3_q.size() < 2 || fall3_q.size() < 1 || start3_q[1] != fall3_q[0] + 6) begin
            n_fail++;
            $display("FAIL delay_second_start: %0d starts recorded, expected second at fall+6", start3_q.size());
        end
        delay3 = 0;
        hold3  = 10;
    endtask

    task automatic test_zero_delay();
        int c, seen;
        start0_q.delete();
        fall0_q.delete();
        q0.push_back(8'hFF);
        q0.push_back(8'h00);
        c = cyc;
        bus0.result_req  = 1'b1;
        bus0.result_data = 16'h00FF;
        @(negedge clk);
        bus0.result_req  = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (bus0.done === 1'b1) seen = 1;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (seen == 0 || done_cnt0 != 1 || start_cnt0 != 2 || q0.size() != 0) begin
            n_fail++;
            $display("FAIL zero_msg: done %0d starts %0d left %0d, expected 1 2 0", done_cnt0, start_cnt0, q0.size());
        end
        n_checks++;
        if (start0_q.size() < 2 || fall0_q.size() < 1) begin
            n_fail++;
            $display("FAIL zero_timing: %0d starts %0d falls recorded", start0_q.size(), fall0_q.size());
        end else begin
            if (start0_q[0] != c + 3) begin
                n_fail++;
                $display("FAIL zero_first_start: cycle %0d, expected %0d", start0_q[0], c + 3);
            end
            n_checks++;
            if (start0_q[1] != fall0_q[0] + 3) begin
                n_fail++;
                $display("FAIL zero_second_start: cycle %0d, expected %0d", start0_q[1], fall0_q[0] + 3);
            end
        end
    endtask

`ifdef TX_ECHO_EN
    task automatic req_both3(input logic [7:0] e, input logic [15:0] r);
        bus3.echo_req    = 1'b1;
        bus3.echo_data   = e;
        bus3.result_req  = 1'b1;
        bus3.result_data = r;
        @(negedge clk);
        bus3.echo_req    = 1'b0;
        bus3.result_req  = 1'b0;
    endtask

    task automatic test_echo();
        int ov0, dn0;
        ov0 = ov_cnt3;
        dn0 = done_cnt3;
        q3.push_back(8'h41);
        q3.push_back(8'h34);
        q3.push_back(8'h12);
        req_both3(8'h41, 16'h1234);
        wait_done3(2, 400, "echo_priority_done");
        repeat (3) @(negedge clk);
        n_checks++;
        if (q3.size() != 0 || done_cnt3 - dn0 != 2 || ov_cnt3 != ov0) begin
            n_fail++;
            $display("FAIL echo_priority: left %0d done %0d ov %0d, expected 0 2 0", q3.size(), done_cnt3 - dn0, ov_cnt3 - ov0);
        end
        q3.push_back(8'h41);
        req_both3(8'h41, 16'h1234);
        wait_start3(50, "echo_overrun_start");
        q3.push_back(8'h78);
        q3.push_back(8'h56);
        req_res3(16'h5678);
        wait_done3(2, 400, "echo_overrun_done");
        repeat (3) @(negedge clk);
        n_checks++;
        if (q3.size() != 0 || ov_cnt3 - ov0 != 1) begin
            n_fail++;
            $display("FAIL echo_overrun: left %0d ov %0d, expected 0 and 1", q3.size(), ov_cnt3 - ov0);
        end
    endtask
`endif

    initial begin
        bus3.result_req  = 1'b0;
        bus3.result_data = '0;
        bus0.result_req  = 1'b0;
        bus0.result_data = '0;
`ifdef TX_ECHO_EN
        bus3.echo_req    = 1'b0;
        bus3.echo_data   = '0;
        bus0.echo_req    = 1'b0;
        bus0.echo_data   = '0;
`endif
        test_reset();
        test_result_split();
        test_pending_overrun();
        test_busy_delay();
        test_zero_delay();
`ifdef TX_ECHO_EN
        test_echo();
`endif
        test_reset_mid_message();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
